lane_scan_loader: RTL and testbench
===================================

Name: lane_scan_loader

Overview:
- Serial-to-array front end for the 5x5 lane state.
- Accepts 25 lanes on a valid/ready stream and walks (i,j) coordinates in scan order.
- Drives i/j to the downstream coordinate-to-index mapper (combinational) and uses the returned index to write each lane into a 25-entry lane register file.
- Exposes an asynchronous read port so the next round logic can read the loaded state.

Parameters:
- LANE_W, 64, width of one lane in bits.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a 25-lane load; sampled only in IDLE.
- in_valid  in  1  upstream lane valid.
- in_lane  in  LANE_W  upstream lane data.
- in_ready  out  1  block can accept a lane this cycle.
- i  out  32  current x coordinate (0..4) to the mapper.
- j  out  32  current y coordinate (0..4) to the mapper.
- convert_num  in  32  mapped linear index (0..24) returned by the mapper for the current i/j.
- busy  out  1  high in LOAD.
- done  out  1  one-cycle pulse when the load completes.
- lane_cnt  out  5  lanes accepted in the current load (0..25).
- err  out  1  sticky flag: an out-of-range index was returned.
- rd_addr  in  5  read index into the lane file.
- rd_data  out  LANE_W  contents of lane file at rd_addr.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE; i=0, j=0; lane_cnt=0; busy=0; done=0; in_ready=0; err=0.
  - All 25 lane entries cleared to 0.
  - Applies immediately, including mid-load; a partial load is discarded.
- States:
  - IDLE: in_ready=0. If start=1, go to LOAD with i=0, j=0, lane_cnt=0; err is not cleared.
  - LOAD: in_ready=1 and busy=1. Accept occurs when in_valid & in_ready.
  - DONE: done=1 for exactly one cycle, in_ready=0, then unconditionally return to IDLE.
- Scan order: i is the inner loop (0..4) and j the outer loop (0..4).
  - On each accept, i increments.
  - When i=4, i wraps to 0 and j increments.
  - The 25th accept (i=4, j=4) wraps both to 0 and moves to DONE.
- Write: on accept, if convert_num <= 24, write mem[convert_num] <= in_lane.
  - Otherwise suppress the write and set err=1.
  - The counters still advance, so a bad index never stalls the scan.
- Mapper contract: index = 5*((j+2) mod 5) + ((i+2) mod 5).
  - The first lane lands in entry 12.
  - The loader does not recompute this; it trusts convert_num, subject only to the range check.
- lane_cnt: increments per accept and holds 25 in DONE. It resets to 0 on the next start.
- Stall: if in_valid=0 in LOAD, i, j, lane_cnt and memory hold.
- Timing:
  - done rises in the cycle following the clock edge of the 25th accept.
  - The minimum load time is 25 cycles of LOAD plus 1 cycle of DONE.
- start outside IDLE (in LOAD or DONE) is ignored. start and in_valid together in IDLE accept no lane that cycle.
- rd_data is combinational: rd_data = mem[rd_addr] for rd_addr <= 24, and 0 for rd_addr 25..31.
  - A read and a write to the same entry in one cycle return the old value.
- i and j are valid in every state; they are 0 in IDLE and DONE.

Test Plan:
- Reset then start, stream lanes 0..24 with in_valid held high:
  - Expect mem[12]=0, mem[13]=1, mem[14]=2, mem[10]=3, mem[11]=4, mem[17]=5, mem[6]=24.
  - done pulses once, 26 cycles after start is seen in LOAD entry; lane_cnt=25 in DONE.
- Same stream with in_valid low on alternate cycles:
  - Identical final memory contents.
  - i, j and lane_cnt frozen during gaps; done arrives 25 valid cycles after LOAD entry.
- Drop rst_n after 7 accepted lanes:
  - Immediately busy=0, in_ready=0, all rd_data=0, i=j=0.
  - A fresh start then loads correctly.
- Pulse start during LOAD (lane 10) and during DONE:
  - No restart; lane_cnt continues 10->11; the DONE cycle returns to IDLE.
- Force convert_num=31 on accept #3:
  - No entry is written; err=1 and stays set after done.
  - The remaining 24 lanes are written normally; lane_cnt reaches 25.
- Read rd_addr=25 and rd_addr=31 after a load: rd_data=0.

Source files
------------

// File: rtl/lane_scan_loader.sv
// Serial-to-array loader for the 5x5 lane state: accepts 25 lanes in (i,j) scan order,
// stores each at the index returned by the external coordinate mapper, and exposes a read port.
module lane_scan_loader #(
    parameter int LANE_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [LANE_W-1:0] in_lane,
    output logic              in_ready,
    output logic [31:0]       i,
    output logic [31:0]       j,
    input  logic [31:0]       convert_num,
    output logic              busy,
    output logic              done,
    output logic [4:0]        lane_cnt,
    output logic              err,
    input  logic [4:0]        rd_addr,
    output logic [LANE_W-1:0] rd_data
);

    localparam int NUM_LANES = 25;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic [2:0]        i_r;
    logic [2:0]        j_r;
    logic [4:0]        lane_cnt_r;
    logic              in_ready_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;
    logic [LANE_W-1:0] mem_r [NUM_LANES];

    logic              accept_s;
    logic              idx_ok_s;
    logic              wr_en_s;
    logic [4:0]        wr_idx_s;

    // The mapper is trusted for the value but not the range; anything past 24 is rejected.
    function automatic logic idx_in_range(input logic [31:0] idx);
        return (idx <= 32'd24);
    endfunction

    assign accept_s = in_valid & in_ready_r;
    assign idx_ok_s = idx_in_range(convert_num);
    assign wr_en_s  = accept_s & idx_ok_s;
    assign wr_idx_s = convert_num[4:0];

    assign in_ready = in_ready_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign lane_cnt = lane_cnt_r;
    assign err      = err_r;
    assign i        = {29'd0, i_r};
    assign j        = {29'd0, j_r};

    // Load sequencer: scan counters, handshake and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            i_r        <= 3'd0;
            j_r        <= 3'd0;
            lane_cnt_r <= 5'd0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r    <= ST_LOAD;
                        i_r        <= 3'd0;
                        j_r        <= 3'd0;
                        lane_cnt_r <= 5'd0;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end else begin
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (accept_s) begin
                        lane_cnt_r <= lane_cnt_r + 5'd1;
                        err_r      <= err_r | ~idx_ok_s;
                        if (i_r == 3'd4) begin
                            i_r <= 3'd0;
                            // Last lane of the last row closes the load.
                            if (j_r == 3'd4) begin
                                j_r        <= 3'd0;
                                state_r    <= ST_DONE;
                                in_ready_r <= 1'b0;
                                busy_r     <= 1'b0;
                                done_r     <= 1'b1;
                            end else begin
                                j_r <= j_r + 3'd1;
                            end
                        end else begin
                            i_r <= i_r + 3'd1;
                        end
                    end else begin
                        lane_cnt_r <= lane_cnt_r;
                    end
                end
                ST_DONE: begin
                    state_r    <= ST_IDLE;
                    done_r     <= 1'b0;
                    in_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    i_r        <= 3'd0;
                    j_r        <= 3'd0;
                    in_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                end
            endcase
        end
    end

    // Lane register file; cleared on reset so an aborted load leaves no stale lanes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                mem_r[k] <= {LANE_W{1'b0}};
            end
        end else if (wr_en_s) begin
            mem_r[wr_idx_s] <= in_lane;
        end
    end

    // Asynchronous read; addresses beyond the file read as zero.
    always_comb begin
        rd_data = {LANE_W{1'b0}};
        if (rd_addr <= 5'd24) begin
            rd_data = mem_r[rd_addr];
        end else begin
            rd_data = {LANE_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_lane_scan_loader.sv
// Randomized bench for lane_scan_loader: a count-based behavioural model predicts every
// output each cycle, and literal expectations pin the mapped placement and timing.
module tb_lane_scan_loader;

    localparam int LANE_W = 64;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              in_valid;
    logic [LANE_W-1:0] in_lane;
    logic              in_ready;
    logic [31:0]       i;
    logic [31:0]       j;
    logic [31:0]       convert_num;
    logic              busy;
    logic              done;
    logic [4:0]        lane_cnt;
    logic              err;
    logic [4:0]        rd_addr;
    logic [LANE_W-1:0] rd_data;

    logic              force_bad;
    logic              sweeping;
    int                checks;
    int                errors;

    // model: 0 idle, 1 loading, 2 done; m_cnt = lanes accepted
    int                m_state;
    int                m_cnt;
    logic              m_err;
    logic [LANE_W-1:0] m_mem [25];

    lane_scan_loader #(.LANE_W(LANE_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_lane(in_lane),
        .in_ready(in_ready), .i(i), .j(j), .convert_num(convert_num), .busy(busy),
        .done(done), .lane_cnt(lane_cnt), .err(err), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream mapper stand-in, optionally forced out of range.
    assign convert_num = force_bad ? 32'd31
                       : (32'd5 * ((j + 32'd2) % 32'd5) + ((i + 32'd2) % 32'd5));

    function automatic int model_idx(input int k, input logic bad);
        if (bad) return 31;
        return 5 * ((k / 5 + 2) % 5) + ((k % 5 + 2) % 5);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= 0;
            m_cnt   <= 0;
            m_err   <= 1'b0;
            for (int k = 0; k < 25; k++) m_mem[k] <= 64'd0;
        end else begin
            case (m_state)
                0: if (start) begin
                    m_state <= 1;
                    m_cnt   <= 0;
                end
                1: if (in_valid) begin
                    if (model_idx(m_cnt, force_bad) <= 24) m_mem[model_idx(m_cnt, force_bad)] <= in_lane;
                    else m_err <= 1'b1;
                    m_cnt <= m_cnt + 1;
                    if (m_cnt == 24) m_state <= 2;
                end
                2: m_state <= 0;
                default: m_state <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n && !sweeping) begin
            chk("in_ready", 64'(in_ready), 64'(m_state == 1));
            chk("busy", 64'(busy), 64'(m_state == 1));
            chk("done", 64'(done), 64'(m_state == 2));
            chk("i", 64'(i), 64'((m_state == 1) ? (m_cnt % 5) : 0));
            chk("j", 64'(j), 64'((m_state == 1) ? (m_cnt / 5) : 0));
            chk("lane_cnt", 64'(lane_cnt), 64'(m_cnt));
            chk("err", 64'(err), 64'(m_err));
            chk("rd_data", rd_data, (rd_addr <= 5'd24) ? m_mem[rd_addr] : 64'd0);
        end
    end

    task automatic rd_pin(input string name, input int addr, input logic [63:0] exp);
        sweeping = 1'b1;
        rd_addr  = 5'(addr);
        #1;
        chk(name, rd_data, exp);
        sweeping = 1'b0;
    endtask

    task automatic sweep_model();
        for (int a = 0; a < 32; a++) begin
            rd_pin("rd_sweep", a, (a <= 24) ? m_mem[a] : 64'd0);
        end
    endtask

    task automatic placement_pins();
        rd_pin("pin_mem12", 12, 64'd0);
        rd_pin("pin_mem13", 13, 64'd1);
        rd_pin("pin_mem14", 14, 64'd2);
        rd_pin("pin_mem10", 10, 64'd3);
        rd_pin("pin_mem11", 11, 64'd4);
        rd_pin("pin_mem17", 17, 64'd5);
        rd_pin("pin_mem6", 6, 64'd24);
    endtask

    // mode: 0 valid always, 1 valid on alternate cycles, 2 random valid
    task automatic do_load(input int mode, input bit seq_data, input int bad_k, input bit pulse,
                           input int abort_k, output int load_cycles, output int done_cycles);
        int c;
        bit seen_done;
        load_cycles = 0;
        done_cycles = 0;
        seen_done   = 1'b0;
        @(posedge clk); #1;
        start    = 1'b1;
        in_valid = 1'b1;
        in_lane  = {$urandom, $urandom};
        @(posedge clk); #1;
        start = 1'b0;
        for (c = 0; c < 400; c++) begin
            if (m_state == 0 && seen_done) break;
            if (abort_k >= 0 && m_state == 1 && m_cnt == abort_k) begin
                in_valid = 1'b0;
                #2 rst_n = 1'b0;
                #1;
                chk("abort_busy", 64'(busy), 64'd0);
                chk("abort_in_ready", 64'(in_ready), 64'd0);
                chk("abort_i", 64'(i), 64'd0);
                chk("abort_j", 64'(j), 64'd0);
                chk("abort_lane_cnt", 64'(lane_cnt), 64'd0);
                for (int a = 0; a < 32; a++) rd_pin("abort_rd_zero", a, 64'd0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (busy) load_cycles++;
            if (done) done_cycles++;
            if (m_state == 2) seen_done = 1'b1;
            rd_addr = 5'($urandom_range(0, 31));
            if (m_state == 1) begin
                in_valid  = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
                in_lane   = seq_data ? 64'(m_cnt) : {$urandom, $urandom};
                force_bad = (m_cnt == bad_k);
                start     = pulse && (m_cnt == 10);
            end else begin
                in_valid  = 1'($urandom_range(0, 1));
                in_lane   = {$urandom, $urandom};
                force_bad = 1'b0;
                start     = pulse;
            end
            @(posedge clk); #1;
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        force_bad = 1'b0;
        if (c >= 400) begin
            errors++;
            $display("FAIL load_timeout: actual=%0d cycles required=completion", c);
        end
    endtask

    initial begin
        int lc;
        int dc;
        logic [63:0] saved10;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_lane   = 64'd0;
        rd_addr   = 5'd0;
        force_bad = 1'b0;
        sweeping  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_lane_cnt", 64'(lane_cnt), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_i", 64'(i), 64'd0);
        chk("rst_rd", rd_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_load(0, 1'b1, -1, 1'b0, -1, lc, dc);
        chk("full_load_cycles", 64'(lc), 64'd25);
        chk("full_done_pulses", 64'(dc), 64'd1);
        chk("full_lane_cnt", 64'(lane_cnt), 64'd25);
        chk("full_err", 64'(err), 64'd0);
        placement_pins();
        sweep_model();

        do_load(1, 1'b1, -1, 1'b0, -1, lc, dc);
        chk("gap_load_cycles", 64'(lc), 64'd49);
        chk("gap_done_pulses", 64'(dc), 64'd1);
        placement_pins();

        do_load(2, 1'b0, -1, 1'b0, 7, lc, dc);
        do_load(2, 1'b0, -1, 1'b1, -1, lc, dc);
        chk("pulse_done_pulses", 64'(dc), 64'd1);
        chk("pulse_lane_cnt", 64'(lane_cnt), 64'd25);
        sweep_model();

        saved10 = m_mem[10];
        do_load(2, 1'b0, 3, 1'b0, -1, lc, dc);
        chk("bad_err", 64'(err), 64'd1);
        chk("bad_lane_cnt", 64'(lane_cnt), 64'd25);
        rd_pin("bad_entry_kept", 10, saved10);
        sweep_model();

        do_load(0, 1'b0, -1, 1'b0, -1, lc, dc);
        chk("err_sticky", 64'(err), 64'd1);
        rd_pin("rd_25_zero", 25, 64'd0);
        rd_pin("rd_31_zero", 31, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
